// File: rtl/write_request_queue_wm_if.sv
// Write-request queue bus: command router / scheduler side of the queue.
// master drives the request inputs (i_*) and observes the queue outputs (o_*).
// slave is the queue itself. clk and reset stay outside as plain ports.
interface write_request_queue_wm_if #(
  parameter int CMD_WIDTH  = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_push;
  logic [CMD_WIDTH-1:0]  i_data;
  logic                  i_pop;
  logic                  i_raw_chk;
  logic [ADDR_WIDTH-1:0] i_raw_addr;
  logic                  i_force_flush;
  logic [CMD_WIDTH-1:0]  o_data;
  logic                  o_empty;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_raw_hit;
  logic                  o_write_flush;

  modport master (
    output i_push, i_data, i_pop, i_raw_chk, i_raw_addr, i_force_flush,
    input  o_data, o_empty, o_full, o_count, o_raw_hit, o_write_flush
  );

  modport slave (
    input  i_push, i_data, i_pop, i_raw_chk, i_raw_addr, i_force_flush,
    output o_data, o_empty, o_full, o_count, o_raw_hit, o_write_flush
  );
endinterface

// File: rtl/write_request_queue_wm.sv
// Write-request queue with watermark/RAW/forced drain control.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave modport): push/pop
// handshake, RAW check address, force flush in; head data, flags, count,
// RAW hit pulse and write-flush request out.
// Latency: a push into an empty queue is visible on o_data one cycle later;
// flags, count, raw hit and flush are all registered.
module write_request_queue_wm #(
  parameter int CMD_WIDTH  = 32,
  parameter int ADDR_LSB   = 2,
  parameter int ADDR_WIDTH = 28,
  parameter int DEPTH_LOG2 = 4,
  parameter int HIGH_WM    = 12,
  parameter int LOW_WM     = 4
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  write_request_queue_wm_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN_WM,
    ST_DRAIN_RAW,
    ST_DRAIN_ALL
  } state_e;

  // Storage (not reset) and per-entry valid bits used by the RAW compare.
  logic [CMD_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] raw_tgt_q, raw_tgt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          raw_hit_q;
  logic          flush_q;
  state_e        state_q, state_d;

  logic                  push_acc;
  logic                  pop_acc;
  logic                  raw_match;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];

  // Acceptance uses the registered flags only: a pop does not make room for
  // a push in the same cycle, and a push does not make a pop legal.
  assign push_acc = bus.i_push && !full_q;
  assign pop_acc  = bus.i_pop  && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop_acc);
    count_d  = count_q + PW'(push_acc) - PW'(pop_acc);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
               (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);

    // Clear before set; with push gated by full the two indices can only
    // coincide when the queue is empty, where the pop is already blocked.
    vld_d = vld_q;
    if (pop_acc)  vld_d[rd_idx] = 1'b0;
    if (push_acc) vld_d[wr_idx] = 1'b1;
  end

  // Associative RAW compare against the registered valid entries, so an
  // entry being popped this cycle still counts, plus the word being pushed.
  always_comb begin
    raw_match = 1'b0;
    if (bus.i_raw_chk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (mem_q[i][ADDR_LSB +: ADDR_WIDTH] == bus.i_raw_addr))
          raw_match = 1'b1;
      end
      if (push_acc && (bus.i_data[ADDR_LSB +: ADDR_WIDTH] == bus.i_raw_addr))
        raw_match = 1'b1;
    end
  end

  // Drain target is the write pointer after this cycle's push: the RAW
  // drain is done once everything present at hit time has left the queue.
  assign raw_tgt_d = raw_match ? wr_ptr_d : raw_tgt_q;

  // Next-state logic, priority force > RAW > watermark in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_force_flush)             state_d = ST_DRAIN_ALL;
        else if (raw_match)                state_d = ST_DRAIN_RAW;
        else if (count_d >= PW'(HIGH_WM))  state_d = ST_DRAIN_WM;
      end
      ST_DRAIN_WM: begin
        if (bus.i_force_flush)             state_d = ST_DRAIN_ALL;
        else if (raw_match)                state_d = ST_DRAIN_RAW;
        else if (count_q <= PW'(LOW_WM))   state_d = ST_IDLE;
      end
      ST_DRAIN_RAW: begin
        if (bus.i_force_flush)             state_d = ST_DRAIN_ALL;
        else if (raw_match)                state_d = ST_DRAIN_RAW;
        else if (rd_ptr_q == raw_tgt_q)
          state_d = (count_d >= PW'(HIGH_WM)) ? ST_DRAIN_WM : ST_IDLE;
      end
      ST_DRAIN_ALL: begin
        if (empty_q && !bus.i_force_flush)
          state_d = (count_d >= PW'(HIGH_WM)) ? ST_DRAIN_WM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wr_idx] <= bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      vld_q     <= '0;
      raw_hit_q <= 1'b0;
      raw_tgt_q <= '0;
      flush_q   <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      vld_q     <= vld_d;
      raw_hit_q <= raw_match;
      raw_tgt_q <= raw_tgt_d;
      // Registered alongside the state so it always equals state != IDLE.
      flush_q   <= (state_d != ST_IDLE);
      state_q   <= state_d;
    end
  end

  assign bus.o_data        = empty_q ? '0 : mem_q[rd_idx];
  assign bus.o_empty       = empty_q;
  assign bus.o_full        = full_q;
  assign bus.o_count       = count_q;
  assign bus.o_raw_hit     = raw_hit_q;
  assign bus.o_write_flush = flush_q;

endmodule

// File: tb/tb_write_request_queue_wm.sv
// Directed bench for write_request_queue_wm: a vector table for the RAW,
// force-flush and empty-pop behaviour, plus hand sequences for full/order,
// watermark hysteresis, streaming wrap-around and reset mid-drain.
module tb_write_request_queue_wm;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  write_request_queue_wm_if #(.CMD_WIDTH(32), .ADDR_WIDTH(28), .DEPTH_LOG2(4)) bus ();

  write_request_queue_wm #(
    .CMD_WIDTH(32), .ADDR_LSB(2), .ADDR_WIDTH(28),
    .DEPTH_LOG2(4), .HIGH_WM(12), .LOW_WM(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic        pop;
    logic        chk;
    logic [27:0] addr;
    logic        frc;
    logic [4:0]  e_cnt;
    logic        e_emp;
    logic        e_full;
    logic [31:0] e_dat;
    logic        e_hit;
    logic        e_fl;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic step(input logic p, input logic [31:0] d, input logic po,
                      input logic c, input logic [27:0] a, input logic f);
    bus.i_push        = p;
    bus.i_data        = d;
    bus.i_pop         = po;
    bus.i_raw_chk     = c;
    bus.i_raw_addr    = a;
    bus.i_force_flush = f;
    @(posedge clk);
    #1;
    bus.i_push        = 1'b0;
    bus.i_data        = '0;
    bus.i_pop         = 1'b0;
    bus.i_raw_chk     = 1'b0;
    bus.i_raw_addr    = '0;
    bus.i_force_flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.i_push = 0; bus.i_data = 0; bus.i_pop = 0;
    bus.i_raw_chk = 0; bus.i_raw_addr = 0; bus.i_force_flush = 0;

    //          push data         pop chk addr      frc  cnt emp ful dat          hit fl
    vt[0]  = '{1, 32'h40,  0, 0, 28'h0,  0, 1, 0, 0, 32'h40,  0, 0};
    vt[1]  = '{1, 32'h80,  0, 0, 28'h0,  0, 2, 0, 0, 32'h40,  0, 0};
    vt[2]  = '{1, 32'hC0,  0, 0, 28'h0,  0, 3, 0, 0, 32'h40,  0, 0};
    vt[3]  = '{0, 32'h0,   0, 1, 28'h99, 0, 3, 0, 0, 32'h40,  0, 0};
    vt[4]  = '{0, 32'h0,   0, 1, 28'h20, 0, 3, 0, 0, 32'h40,  1, 1};
    vt[5]  = '{0, 32'h0,   0, 0, 28'h0,  0, 3, 0, 0, 32'h40,  0, 1};
    vt[6]  = '{1, 32'h100, 0, 0, 28'h0,  0, 4, 0, 0, 32'h40,  0, 1};
    vt[7]  = '{1, 32'h140, 0, 0, 28'h0,  0, 5, 0, 0, 32'h40,  0, 1};
    vt[8]  = '{0, 32'h0,   1, 0, 28'h0,  0, 4, 0, 0, 32'h80,  0, 1};
    vt[9]  = '{0, 32'h0,   1, 0, 28'h0,  0, 3, 0, 0, 32'hC0,  0, 1};
    vt[10] = '{0, 32'h0,   1, 0, 28'h0,  0, 2, 0, 0, 32'h100, 0, 1};
    vt[11] = '{0, 32'h0,   0, 0, 28'h0,  0, 2, 0, 0, 32'h100, 0, 0};
    vt[12] = '{1, 32'h180, 0, 1, 28'h60, 0, 3, 0, 0, 32'h100, 1, 1};
    vt[13] = '{0, 32'h0,   1, 0, 28'h0,  0, 2, 0, 0, 32'h140, 0, 1};
    vt[14] = '{0, 32'h0,   1, 0, 28'h0,  0, 1, 0, 0, 32'h180, 0, 1};
    vt[15] = '{0, 32'h0,   1, 0, 28'h0,  0, 0, 1, 0, 32'h0,   0, 1};
    vt[16] = '{0, 32'h0,   0, 0, 28'h0,  0, 0, 1, 0, 32'h0,   0, 0};
    vt[17] = '{1, 32'h1C0, 1, 0, 28'h0,  0, 1, 0, 0, 32'h1C0, 0, 0};
    vt[18] = '{0, 32'h0,   0, 0, 28'h0,  1, 1, 0, 0, 32'h1C0, 0, 1};
    vt[19] = '{0, 32'h0,   1, 0, 28'h0,  1, 0, 1, 0, 32'h0,   0, 1};
    vt[20] = '{0, 32'h0,   0, 0, 28'h0,  0, 0, 1, 0, 32'h0,   0, 0};
    vt[21] = '{0, 32'h0,   0, 1, 28'h10, 0, 0, 1, 0, 32'h0,   0, 0};

    // Reset state.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_full",  32'(bus.o_full),  32'd0);
    chk("rst_hit",   32'(bus.o_raw_hit), 32'd0);
    chk("rst_flush", 32'(bus.o_write_flush), 32'd0);
    chk("rst_data",  bus.o_data, 32'd0);
    rst_n = 1'b1;

    // Vector table: RAW hit/miss, RAW drain exit, push-side match,
    // empty pop with push, forced drain, popped entries leave the compare.
    for (int i = 0; i < 22; i++) begin
      step(vt[i].push, vt[i].data, vt[i].pop, vt[i].chk, vt[i].addr, vt[i].frc);
      chk($sformatf("v%0d_count", i), 32'(bus.o_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus.o_empty), 32'(vt[i].e_emp));
      chk($sformatf("v%0d_full",  i), 32'(bus.o_full),  32'(vt[i].e_full));
      chk($sformatf("v%0d_data",  i), bus.o_data, vt[i].e_dat);
      chk($sformatf("v%0d_hit",   i), 32'(bus.o_raw_hit), 32'(vt[i].e_hit));
      chk($sformatf("v%0d_flush", i), 32'(bus.o_write_flush), 32'(vt[i].e_fl));
    end

    // Fill to full, dropped pushes, in-order drain.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1, 32'hA000 + 32'(k), 0, 0, 0, 0);
      chk($sformatf("fill%0d_count", k), 32'(bus.o_count), 32'(k + 1));
    end
    chk("fill_full", 32'(bus.o_full), 32'd1);
    step(1, 32'hDEAD, 0, 0, 0, 0);
    chk("drop_count", 32'(bus.o_count), 32'd16);
    chk("drop_full",  32'(bus.o_full),  32'd1);
    chk("drain0_data", bus.o_data, 32'hA000);
    // Push while full with a pop: push still dropped.
    step(1, 32'hBEEF, 1, 0, 0, 0);
    chk("fullpp_count", 32'(bus.o_count), 32'd15);
    chk("fullpp_full",  32'(bus.o_full),  32'd0);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("drain%0d_data", k), bus.o_data, 32'hA000 + 32'(k));
      step(0, 0, 1, 0, 0, 0);
    end
    chk("drain_empty", 32'(bus.o_empty), 32'd1);
    chk("drain_count", 32'(bus.o_count), 32'd0);

    // Watermark hysteresis: rise at 12, fall one cycle after count reaches 4.
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1, 32'(k), 0, 0, 0, 0);
      chk($sformatf("wm_push%0d_flush", k), 32'(bus.o_write_flush), 32'(k == 12));
    end
    for (int j = 1; j <= 8; j++) begin
      step(0, 0, 1, 0, 0, 0);
      chk($sformatf("wm_pop%0d_count", j), 32'(bus.o_count), 32'(12 - j));
      chk($sformatf("wm_pop%0d_flush", j), 32'(bus.o_write_flush), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("wm_exit_flush", 32'(bus.o_write_flush), 32'd0);
    chk("wm_exit_count", 32'(bus.o_count), 32'd4);

    // Streaming push+pop at count 3 across pointer wrap.
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 32'h1000 + 32'(k), 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("st%0d_data", k), bus.o_data,
          (k < 3) ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k - 3));
      step(1, 32'h2000 + 32'(k), 1, 0, 0, 0);
      chk($sformatf("st%0d_count", k), 32'(bus.o_count), 32'd3);
    end
    chk("st_flush", 32'(bus.o_write_flush), 32'd0);

    // Reset while in a watermark drain at count 10.
    do_reset();
    for (int k = 0; k < 12; k++) step(1, 32'(k), 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("mid_count", 32'(bus.o_count), 32'd10);
    chk("mid_flush", 32'(bus.o_write_flush), 32'd1);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("mrst_count", 32'(bus.o_count), 32'd0);
    chk("mrst_empty", 32'(bus.o_empty), 32'd1);
    chk("mrst_flush", 32'(bus.o_write_flush), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("mrst_flush2", 32'(bus.o_write_flush), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
